router_pkt_fifo: RTL

Parametrised, packet-aware synchronous FIFO for the router output channels, successor to the fixed 8x16 channel FIFO. Stores each word with a header tag and tracks how many words of the current packet remain on the read side. Replaces tri-stated idle output with an explicit `data_valid`, and adds occupancy, almost-full and optional parity checking. One instance per destination port, between the router FSM/synchroniser and the output read interface.

---
 rtl/router_pkg.sv | 17 +
 rtl/router_fifo_mem.sv | 26 ++
 rtl/router_pkt_fifo.sv | 129 ++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: header field positions and header length extraction.
// Used by the router FSM, register blocks and the packet FIFO.
package router_pkg;

  localparam int HDR_ADDR_LSB   = 0;
  localparam int HDR_ADDR_MSB   = 1;
  localparam int HDR_LEN_LSB    = HDR_ADDR_MSB + 1;
  localparam int HDR_WORD_MAX_W = 64;

  typedef logic [HDR_WORD_MAX_W-1:0] hdr_word_t;

  // Callers zero-extend their word to hdr_word_t and size-cast the result back.
  function automatic hdr_word_t hdr_len(input hdr_word_t word);
    return word >> HDR_LEN_LSB;
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Register-file storage for router_pkt_fifo: one synchronous write port,
// one asynchronous read port, array not reset.
module router_fifo_mem
  import router_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO with registered read port, packet tracker and
// occupancy flags. Define ROUTER_FIFO_PARITY_CHK_EN to enable the parity checker.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 16,
  parameter  int AF_MARGIN = 2,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int LEN_W     = DATA_W - 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic [LEN_W:0]    pkt_remaining,
  output logic              pkt_active,
  output logic              pkt_trunc,
  output logic              parity_err
);

  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic              push_p0, pop_p0;
  logic [DATA_W:0]   rd_word_p0;
  logic              rd_tag_p0;
  logic [DATA_W-1:0] rd_data_p0;
  logic [LEN_W:0]    hdr_rem_p0;

  router_fifo_mem #(
    .WIDTH  (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push_p0),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data ({lfd_state, data_in}),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_word_p0)
  );

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr == {~rd_ptr[ADDR_W], rd_ptr[ADDR_W-1:0]});
  assign almost_full = (count >= (ADDR_W+1)'(DEPTH - AF_MARGIN));
  assign pkt_active  = (pkt_remaining != '0);

  assign push_p0    = write_enb && !full;
  assign pop_p0     = read_enb && !empty;
  assign rd_tag_p0  = rd_word_p0[DATA_W];
  assign rd_data_p0 = rd_word_p0[DATA_W-1:0];
  // Header pop loads payload length plus the trailing parity byte.
  assign hdr_rem_p0 = {1'b0, LEN_W'(hdr_len(HDR_WORD_MAX_W'(rd_data_p0)))} + (LEN_W+1)'(1);

  // Read stage: pop registers the word and updates the packet tracker.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pkt_remaining <= '0;
      pkt_trunc     <= 1'b0;
      data_valid    <= 1'b0;
      data_out      <= '0;
    end else if (soft_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pkt_remaining <= '0;
      pkt_trunc     <= 1'b0;
      data_valid    <= 1'b0;
    end else begin
      data_valid <= pop_p0;
      pkt_trunc  <= 1'b0;
      if (push_p0) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      if (pop_p0) begin
        rd_ptr   <= rd_ptr + (ADDR_W+1)'(1);
        data_out <= rd_data_p0;
        if (rd_tag_p0) begin
          pkt_remaining <= hdr_rem_p0;
          pkt_trunc     <= pkt_active;
        end else if (pkt_active) begin
          pkt_remaining <= pkt_remaining - (LEN_W+1)'(1);
        end
      end
      case ({push_p0, pop_p0})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ROUTER_FIFO_PARITY_CHK_EN
  logic [DATA_W-1:0] par_acc;

  // Parity stage: check fires on the pop that completes the packet.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      par_acc    <= '0;
      parity_err <= 1'b0;
    end else if (soft_reset) begin
      par_acc    <= '0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (pop_p0) begin
        if (rd_tag_p0) begin
          par_acc <= rd_data_p0;
        end else if (pkt_active) begin
          par_acc <= par_acc ^ rd_data_p0;
          if (pkt_remaining == (LEN_W+1)'(1)) parity_err <= |(par_acc ^ rd_data_p0);
        end
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
